fa_lane_adder: RTL and testbench

- Registered bank of 1-bit full adders; each lane computes sum = a^b^c and carry = majority(a,b,c).
- Optional ripple mode chains lanes into a LANES-bit adder.
- Sits behind a modport-style bundle: DUT side drives sum/carry, bench side drives a/b/c.
- Used as a small arithmetic primitive and interface-bundle reference block.

---
 rtl/fa_lane_adder.sv | 74 +++++++
 tb/tb_fa_lane_adder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_lane_adder.sv
// Registered bank of LANES 1-bit full adders; mode=1 chains the lanes into a
// LANES-bit ripple-carry adder with c[0] as the carry-in.
module fa_lane_adder #(
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  output logic             out_valid,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry,
  output logic             carry_out
);

  logic [LANES-1:0] s_c;
  logic [LANES-1:0] k_c;
  logic             cin;
  logic             chain;

  logic [LANES-1:0] sum_d, sum_q;
  logic [LANES-1:0] carry_d, carry_q;
  logic             carry_out_d, carry_out_q;
  logic             out_valid_d, out_valid_q;

  // chain carries the previous lane's carry-out so ripple mode can pick it up
  always_comb begin
    s_c   = '0;
    k_c   = '0;
    cin   = 1'b0;
    chain = c[0];
    for (int i = 0; i < LANES; i++) begin
      cin    = mode ? chain : c[i];
      s_c[i] = a[i] ^ b[i] ^ cin;
      k_c[i] = (a[i] & b[i]) | (b[i] & cin) | (cin & a[i]);
      chain  = k_c[i];
    end
  end

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d       = s_c;
      carry_d     = k_c;
      carry_out_d = k_c[LANES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_q     <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign carry_out = carry_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fa_lane_adder.sv
// Directed and random checks of fa_lane_adder (LANES=8) in both modes,
// including asynchronous reset, hold behaviour and back-to-back operation.
module tb_fa_lane_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       mode;
  logic [7:0] a, b, c;
  logic       out_valid;
  logic [7:0] sum, carry;
  logic       carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  fa_lane_adder #(.LANES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .sum       (sum),
    .carry     (carry),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic m, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [7:0] ic);
    in_valid = v;
    mode     = m;
    a        = ia;
    b        = ib;
    c        = ic;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns {carry, sum}; independent lanes by bit counting, ripple by integer addition
  function automatic logic [15:0] model(input logic m, input logic [7:0] ia,
                                        input logic [7:0] ib, input logic [7:0] ic);
    logic [7:0] s, k, mask;
    logic [1:0] n;
    logic [8:0] t, full;
    s = '0;
    k = '0;
    if (!m) begin
      for (int i = 0; i < 8; i++) begin
        n    = 2'(ia[i]) + 2'(ib[i]) + 2'(ic[i]);
        s[i] = n[0];
        k[i] = n[1];
      end
    end else begin
      full = 9'(ia) + 9'(ib) + 9'(ic[0]);
      s    = full[7:0];
      for (int i = 0; i < 8; i++) begin
        mask = 8'hFF >> (7 - i);
        t    = 9'(ia & mask) + 9'(ib & mask) + 9'(ic[0]);
        k[i] = t[i+1];
      end
    end
    return {k, s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i[0], 8'hFF - 8'(i), 8'h5A, 8'hFF);
      tick();
      n_checks++;
      if ({out_valid, carry_out, carry, sum} !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got ov=%b co=%b carry=%h sum=%h, want all 0",
                 out_valid, carry_out, carry, sum);
      end
    end
    #3 rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'hF0, 8'hCC, 8'hAA);
    tick();
    n_checks++;
    if ({out_valid, sum} !== {1'b1, 8'h96}) begin
      n_fail++;
      $display("FAIL reset_first_capture: got ov=%b sum=%h, want ov=1 sum=96", out_valid, sum);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, carry_out, carry, sum} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_async: got ov=%b co=%b carry=%h sum=%h, want all 0",
               out_valid, carry_out, carry, sum);
    end
    tick();
    #2 rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    tick();
    n_checks++;
    if ({out_valid, carry_out, carry, sum} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got ov=%b co=%b carry=%h sum=%h, want all 0",
               out_valid, carry_out, carry, sum);
    end
  endtask

  task automatic test_truth_table();
    logic [2:0] vec [5] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b111};
    logic [1:0] exp [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11}; // {carry, sum}
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, {7'b0, vec[i][2]}, {7'b0, vec[i][1]}, {7'b0, vec[i][0]});
      tick();
      n_checks++;
      if ({out_valid, carry, sum} !== {1'b1, 7'b0, exp[i][1], 7'b0, exp[i][0]}) begin
        n_fail++;
        $display("FAIL truth_table abc=%b: got ov=%b carry=%h sum=%h, want ov=1 carry=%h sum=%h",
                 vec[i], out_valid, carry, sum, {7'b0, exp[i][1]}, {7'b0, exp[i][0]});
      end
    end
  endtask

  task automatic test_independent();
    drive(1'b1, 1'b0, 8'hF0, 8'hCC, 8'hAA);
    tick();
    n_checks++;
    if ({out_valid, carry_out, carry, sum} !== {1'b1, 1'b1, 8'hE8, 8'h96}) begin
      n_fail++;
      $display("FAIL independent: got ov=%b co=%b carry=%h sum=%h, want 1 1 e8 96",
               out_valid, carry_out, carry, sum);
    end
  endtask

  task automatic test_ripple();
    drive(1'b1, 1'b1, 8'hFF, 8'h00, 8'h01);
    tick();
    n_checks++;
    if ({out_valid, carry_out, carry, sum} !== {1'b1, 1'b1, 8'hFF, 8'h00}) begin
      n_fail++;
      $display("FAIL ripple_ff: got ov=%b co=%b carry=%h sum=%h, want 1 1 ff 00",
               out_valid, carry_out, carry, sum);
    end
    drive(1'b1, 1'b1, 8'h5A, 8'h3C, 8'hFE);
    tick();
    n_checks++;
    if ({out_valid, carry_out, carry, sum} !== {1'b1, 1'b0, 8'h78, 8'h96}) begin
      n_fail++;
      $display("FAIL ripple_5a3c: got ov=%b co=%b carry=%h sum=%h, want 1 0 78 96",
               out_valid, carry_out, carry, sum);
    end
  endtask

  task automatic test_hold_valid();
    logic       v   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] va  [4] = '{8'h0F, 8'hFF, 8'hAA, 8'h33};
    logic [7:0] vb  [4] = '{8'h01, 8'hFF, 8'h55, 8'h55};
    logic [7:0] vc  [4] = '{8'h00, 8'hFF, 8'h0F, 8'h0F};
    logic [7:0] es  [4] = '{8'h0E, 8'h0E, 8'h0E, 8'h69};
    logic [7:0] ek  [4] = '{8'h01, 8'h01, 8'h01, 8'h17};
    for (int i = 0; i < 4; i++) begin
      drive(v[i], 1'b0, va[i], vb[i], vc[i]);
      tick();
      n_checks++;
      if ({out_valid, carry_out, carry, sum} !== {v[i], 1'b0, ek[i], es[i]}) begin
        n_fail++;
        $display("FAIL hold_valid step %0d: got ov=%b co=%b carry=%h sum=%h, want %b 0 %h %h",
                 i, out_valid, carry_out, carry, sum, v[i], ek[i], es[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [7:0]  ra, rb, rc;
    logic        rm;
    int          errs = 0;
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rm = 1'($urandom);
      drive(1'b1, rm, ra, rb, rc);
      exp = model(rm, ra, rb, rc);
      tick();
      n_checks++;
      if ({out_valid, carry_out, carry, sum} !== {1'b1, exp[15], exp}) begin
        n_fail++;
        errs++;
        if (errs <= 5)
          $display("FAIL back_to_back %0d m=%b a=%h b=%h c=%h: got ov=%b co=%b carry=%h sum=%h, want 1 %b %h %h",
                   i, rm, ra, rb, rc, out_valid, carry_out, carry, sum, exp[15], exp[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] exp;
    logic [7:0]  ea, eb, ec;
    logic [2:0]  combo;
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 8; l++) begin
        combo = 3'(l + r);
        ea[l] = combo[2];
        eb[l] = combo[1];
        ec[l] = combo[0];
      end
      drive(1'b1, 1'b0, ea, eb, ec);
      exp = model(1'b0, ea, eb, ec);
      tick();
      n_checks++;
      if ({out_valid, carry_out, carry, sum} !== {1'b1, exp[15], exp}) begin
        n_fail++;
        $display("FAIL exhaustive rot %0d: got ov=%b co=%b carry=%h sum=%h, want 1 %b %h %h",
                 r, out_valid, carry_out, carry, sum, exp[15], exp[15:8], exp[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_independent();
    test_ripple();
    test_hold_valid();
    test_back_to_back();
    test_exhaustive();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
